// File: rtl/rv32v_arch_csr_if.sv
// rv32v_arch_csr_if -- CSR-instruction access bus for the vector CSR block.
//   csr_wen/csr_addr/csr_wdata : single-cycle CSR write from the CSR instruction path
//   csr_raddr/csr_rdata        : combinational CSR read port
// master: the CSR instruction path; slave: rv32v_arch_csr.
interface rv32v_arch_csr_if;
  logic        csr_wen;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;

  modport master (
    output csr_wen, csr_addr, csr_wdata, csr_raddr,
    input  csr_rdata
  );

  modport slave (
    input  csr_wen, csr_addr, csr_wdata, csr_raddr,
    output csr_rdata
  );
endinterface

// File: rtl/rv32v_arch_csr.sv
// rv32v_arch_csr -- architectural vector CSR state (vtype, vl, vstart, vxrm, vxsat).
//   CLK, nRST              : clock, synchronous active-low reset
//   vset_commit/vkeepvl    : vsetvl-family retirement, keep-vl variant
//   avl, vtype_req         : requested AVL and vtype of the retiring vsetvl
//   vl_spec, vtype_spec    : values the decode shadow assumed for that vsetvl
//   csr (slave)            : CSR-instruction write and combinational read
//   vxsat_set              : sticky saturation event from vector execute
//   vstart_wen/_wdata      : trap-time vstart capture
//   vec_retire             : a vector instruction completed (clears vstart)
//   vtype_arch .. vxsat    : architectural state outputs
//   vl_rd                  : vl for rd writeback, new value in the commit cycle
//   flush_decode           : registered request to reload the decode shadow
package rv32v_pkg;
  typedef struct packed {
    logic       vill;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  localparam logic [2:0] SEW32 = 3'b010;
endpackage

module rv32v_arch_csr
  import rv32v_pkg::*;
#(
  parameter int VLMAX = 32,
  parameter int VLENB = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        vset_commit,
  input  logic        vkeepvl,
  input  logic [31:0] avl,
  input  vtype_t      vtype_req,
  input  logic [31:0] vl_spec,
  input  vtype_t      vtype_spec,
  rv32v_arch_csr_if.slave csr,
  input  logic        vxsat_set,
  input  logic        vstart_wen,
  input  logic [31:0] vstart_wdata,
  input  logic        vec_retire,
  output vtype_t      vtype_arch,
  output logic [31:0] vl_arch,
  output logic [31:0] vstart,
  output logic [1:0]  vxrm,
  output logic        vxsat,
  output logic [31:0] vl_rd,
  output logic        flush_decode
);
  localparam logic [31:0] VLMAX_W = 32'(VLMAX);
  localparam logic [31:0] VLENB_W = 32'(VLENB);

  vtype_t      vtype_q, vtype_d, vtype_new;
  logic [31:0] vl_q, vl_d, vl_new;
  logic [31:0] vstart_q, vstart_d;
  logic [1:0]  vxrm_q, vxrm_d;
  logic        vxsat_q, vxsat_d;
  logic        flush_q, flush_d;
  logic        vtype_illegal, spec_mismatch;
  logic        wr_vstart, wr_vxsat, wr_vxrm, wr_vcsr;

  // The decode shadow never tracks vma/vta, so they take no part in the compare.
  logic unused_spec_bits;
  assign unused_spec_bits = vtype_spec.vma ^ vtype_spec.vta;

  always_comb begin
    vl_new        = vkeepvl ? vl_q : ((avl <= VLMAX_W) ? avl : VLMAX_W);
    // Only SEW<=32 with undisturbed tail/mask policies is supported.
    vtype_illegal = (vtype_req.vsew > SEW32) | vtype_req.vta | vtype_req.vma;
    vtype_new     = '0;
    if (vtype_illegal) begin
      vtype_new.vill = 1'b1;
    end else begin
      vtype_new.vsew  = vtype_req.vsew;
      vtype_new.vlmul = vtype_req.vlmul;
    end
    spec_mismatch = (vl_new != vl_spec)
                  | (vtype_new.vill  != vtype_spec.vill)
                  | (vtype_new.vsew  != vtype_spec.vsew)
                  | (vtype_new.vlmul != vtype_spec.vlmul);
  end

  always_comb begin
    wr_vstart = csr.csr_wen && (csr.csr_addr == 12'h008);
    wr_vxsat  = csr.csr_wen && (csr.csr_addr == 12'h009);
    wr_vxrm   = csr.csr_wen && (csr.csr_addr == 12'h00A);
    wr_vcsr   = csr.csr_wen && (csr.csr_addr == 12'h00F);

    vtype_d  = vtype_q;
    vl_d     = vl_q;
    vstart_d = vstart_q;
    vxrm_d   = vxrm_q;
    vxsat_d  = vxsat_q;
    flush_d  = vset_commit & spec_mismatch;

    if (vset_commit) begin
      vtype_d = vtype_new;
      vl_d    = vl_new;
    end

    if (vstart_wen)      vstart_d = vstart_wdata;
    else if (wr_vstart)  vstart_d = csr.csr_wdata;
    else if (vec_retire) vstart_d = '0;

    if (wr_vxrm)      vxrm_d = csr.csr_wdata[1:0];
    else if (wr_vcsr) vxrm_d = csr.csr_wdata[2:1];

    // An explicit CSR write overrides a concurrent saturation event.
    if (wr_vxsat || wr_vcsr) vxsat_d = csr.csr_wdata[0];
    else if (vxsat_set)      vxsat_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      vtype_q  <= '0;
      vl_q     <= '0;
      vstart_q <= '0;
      vxrm_q   <= '0;
      vxsat_q  <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      vtype_q  <= vtype_d;
      vl_q     <= vl_d;
      vstart_q <= vstart_d;
      vxrm_q   <= vxrm_d;
      vxsat_q  <= vxsat_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    case (csr.csr_raddr)
      12'h008: csr.csr_rdata = vstart_q;
      12'h009: csr.csr_rdata = {31'b0, vxsat_q};
      12'h00A: csr.csr_rdata = {30'b0, vxrm_q};
      12'h00F: csr.csr_rdata = {29'b0, vxrm_q, vxsat_q};
      12'hC20: csr.csr_rdata = vl_q;
      12'hC21: csr.csr_rdata = {vtype_q.vill, 23'b0, vtype_q.vma, vtype_q.vta,
                                vtype_q.vsew, vtype_q.vlmul};
      12'hC22: csr.csr_rdata = VLENB_W;
      default: csr.csr_rdata = '0;
    endcase
  end

  assign vtype_arch   = vtype_q;
  assign vl_arch      = vl_q;
  assign vstart       = vstart_q;
  assign vxrm         = vxrm_q;
  assign vxsat        = vxsat_q;
  assign vl_rd        = vset_commit ? vl_new : vl_q;
  assign flush_decode = flush_q;
endmodule

// File: tb/tb_rv32v_arch_csr.sv
// tb_rv32v_arch_csr -- directed scenarios plus randomized traffic against a
// behavioural model of the vector CSR state.
module tb_rv32v_arch_csr;
  import rv32v_pkg::*;

  localparam int VLMAX = 32;
  localparam int VLENB = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        vset_commit, vkeepvl;
  logic [31:0] avl, vl_spec;
  vtype_t      vtype_req, vtype_spec;
  logic        vxsat_set, vstart_wen, vec_retire;
  logic [31:0] vstart_wdata;
  vtype_t      vtype_arch;
  logic [31:0] vl_arch, vstart, vl_rd;
  logic [1:0]  vxrm;
  logic        vxsat, flush_decode;

  rv32v_arch_csr_if csr_bus();

  rv32v_arch_csr #(.VLMAX(VLMAX), .VLENB(VLENB)) dut (
    .CLK(CLK), .nRST(nRST),
    .vset_commit(vset_commit), .vkeepvl(vkeepvl), .avl(avl),
    .vtype_req(vtype_req), .vl_spec(vl_spec), .vtype_spec(vtype_spec),
    .csr(csr_bus),
    .vxsat_set(vxsat_set), .vstart_wen(vstart_wen), .vstart_wdata(vstart_wdata),
    .vec_retire(vec_retire),
    .vtype_arch(vtype_arch), .vl_arch(vl_arch), .vstart(vstart), .vxrm(vxrm),
    .vxsat(vxsat), .vl_rd(vl_rd), .flush_decode(flush_decode)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  // Behavioural model of the architectural state.
  longint unsigned m_vl = 0, m_vstart = 0;
  int  m_vsew = 0, m_vlmul = 0, m_vxrm = 0;
  bit  m_vill = 0, m_vxsat = 0, m_flush = 0;

  logic [31:0] seen_vl_rd, seen_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic vtype_t mk_vtype(bit ill, bit ma, bit ta, int sew, int lmul);
    vtype_t v;
    v.vill = ill; v.vma = ma; v.vta = ta;
    v.vsew = 3'(sew); v.vlmul = 3'(lmul);
    return v;
  endfunction

  function automatic longint unsigned model_new_vl();
    if (vkeepvl) return m_vl;
    if (longint'(avl) <= VLMAX) return longint'(avl);
    return VLMAX;
  endfunction

  function automatic logic [31:0] model_read(logic [11:0] a);
    case (a)
      12'h008: return 32'(m_vstart);
      12'h009: return 32'(m_vxsat);
      12'h00A: return 32'(m_vxrm);
      12'h00F: return 32'(m_vxrm * 2 + int'(m_vxsat));
      12'hC20: return 32'(m_vl);
      12'hC21: return 32'((longint'(m_vill) << 31) + m_vsew * 8 + m_vlmul);
      12'hC22: return 32'(VLENB);
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_inputs();
    nRST = 1'b1; vset_commit = 1'b0; vkeepvl = 1'b0; avl = '0;
    vtype_req = '0; vl_spec = '0; vtype_spec = '0;
    csr_bus.csr_wen = 1'b0; csr_bus.csr_addr = '0; csr_bus.csr_wdata = '0;
    csr_bus.csr_raddr = '0;
    vxsat_set = 1'b0; vstart_wen = 1'b0; vstart_wdata = '0; vec_retire = 1'b0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check state.
  task automatic step();
    longint unsigned n_vl, n_vstart, nv;
    int  n_vsew, n_vlmul, n_vxrm;
    bit  n_vill, n_vxsat, n_flush, ill, csr_sat;
    @(negedge CLK);
    seen_vl_rd = vl_rd;
    seen_rdata = csr_bus.csr_rdata;
    check_eq("vl_rd", vl_rd, vset_commit ? 32'(model_new_vl()) : 32'(m_vl));
    check_eq("csr_rdata", csr_bus.csr_rdata, model_read(csr_bus.csr_raddr));

    n_vl = m_vl; n_vstart = m_vstart; n_vsew = m_vsew; n_vlmul = m_vlmul;
    n_vxrm = m_vxrm; n_vill = m_vill; n_vxsat = m_vxsat; n_flush = 0;
    if (!nRST) begin
      n_vl = 0; n_vstart = 0; n_vsew = 0; n_vlmul = 0; n_vxrm = 0;
      n_vill = 0; n_vxsat = 0;
    end else begin
      if (vset_commit) begin
        nv  = model_new_vl();
        ill = (vtype_req.vsew > 3'd2) || vtype_req.vta || vtype_req.vma;
        n_vl    = nv;
        n_vill  = ill;
        n_vsew  = ill ? 0 : int'(vtype_req.vsew);
        n_vlmul = ill ? 0 : int'(vtype_req.vlmul);
        n_flush = (nv != longint'(vl_spec)) || (n_vill != vtype_spec.vill) ||
                  (n_vsew != int'(vtype_spec.vsew)) || (n_vlmul != int'(vtype_spec.vlmul));
      end
      csr_sat = 0;
      if (csr_bus.csr_wen) begin
        case (csr_bus.csr_addr)
          12'h009: begin n_vxsat = csr_bus.csr_wdata[0]; csr_sat = 1; end
          12'h00A: n_vxrm = int'(csr_bus.csr_wdata & 32'd3);
          12'h00F: begin
            n_vxrm  = int'((csr_bus.csr_wdata >> 1) & 32'd3);
            n_vxsat = csr_bus.csr_wdata[0];
            csr_sat = 1;
          end
          default: ;
        endcase
      end
      if (vxsat_set && !csr_sat) n_vxsat = 1;
      if (vstart_wen) n_vstart = vstart_wdata;
      else if (csr_bus.csr_wen && csr_bus.csr_addr == 12'h008) n_vstart = csr_bus.csr_wdata;
      else if (vec_retire) n_vstart = 0;
    end

    @(posedge CLK);
    #1;
    m_vl = n_vl; m_vstart = n_vstart; m_vsew = n_vsew; m_vlmul = n_vlmul;
    m_vxrm = n_vxrm; m_vill = n_vill; m_vxsat = n_vxsat; m_flush = n_flush;

    check_eq("vl_arch", vl_arch, 32'(m_vl));
    check_eq("vtype_arch", {23'b0, vtype_arch}, 32'(int'(m_vill) * 256 + m_vsew * 8 + m_vlmul));
    check_eq("vstart", vstart, 32'(m_vstart));
    check_eq("vxrm", {30'b0, vxrm}, 32'(m_vxrm));
    check_eq("vxsat", {31'b0, vxsat}, 32'(m_vxsat));
    check_eq("flush_decode", {31'b0, flush_decode}, 32'(m_flush));
    txn++;
    $display("txn %0d: rst_n=%0b commit=%0b avl=0x%0h wen=%0b addr=0x%03h vl=%0d vstart=%0d flush=%0b",
             txn, nRST, vset_commit, avl, csr_bus.csr_wen, csr_bus.csr_addr,
             vl_arch, vstart, flush_decode);
  endtask

  logic [11:0] addr_tab [8];

  initial begin
    addr_tab = '{12'h008, 12'h009, 12'h00A, 12'h00F, 12'hC20, 12'hC21, 12'hC22, 12'h123};
    clear_inputs();
    nRST = 1'b0;
    step();
    step();
    check_eq("reset_vl", vl_arch, 32'd0);
    check_eq("reset_flush", {31'b0, flush_decode}, 32'd0);

    // Matching commit with avl above VLMAX.
    clear_inputs();
    vset_commit = 1; avl = 100;
    vtype_req = mk_vtype(0, 0, 0, 2, 0); vl_spec = 32; vtype_spec = mk_vtype(0, 0, 0, 2, 0);
    step();
    check_eq("c1_vl_rd", seen_vl_rd, 32'd32);
    check_eq("c1_vl", vl_arch, 32'd32);
    check_eq("c1_flush", {31'b0, flush_decode}, 32'd0);
    clear_inputs();
    step();
    check_eq("c1_flush_after", {31'b0, flush_decode}, 32'd0);

    // vl mismatch pulses flush for exactly one cycle.
    clear_inputs();
    vset_commit = 1; avl = 5;
    vtype_req = mk_vtype(0, 0, 0, 2, 0); vl_spec = 8; vtype_spec = mk_vtype(0, 0, 0, 2, 0);
    step();
    check_eq("c2_vl", vl_arch, 32'd5);
    check_eq("c2_flush", {31'b0, flush_decode}, 32'd1);
    clear_inputs();
    step();
    check_eq("c2_flush_drop", {31'b0, flush_decode}, 32'd0);

    // vta=1 makes vtype illegal.
    clear_inputs();
    vset_commit = 1; avl = 5;
    vtype_req = mk_vtype(0, 0, 1, 2, 0); vl_spec = 5; vtype_spec = mk_vtype(0, 0, 0, 2, 0);
    step();
    check_eq("c3_flush", {31'b0, flush_decode}, 32'd1);
    clear_inputs();
    csr_bus.csr_raddr = 12'hC21;
    step();
    check_eq("c3_vtype_rd", seen_rdata, 32'h8000_0000);

    // vcsr write beats concurrent saturation, then vxsat write clears it.
    clear_inputs();
    csr_bus.csr_wen = 1; csr_bus.csr_addr = 12'h00F; csr_bus.csr_wdata = 32'h5; vxsat_set = 1;
    step();
    check_eq("c4_vxrm", {30'b0, vxrm}, 32'd2);
    check_eq("c4_vxsat", {31'b0, vxsat}, 32'd1);
    clear_inputs();
    csr_bus.csr_wen = 1; csr_bus.csr_addr = 12'h009; csr_bus.csr_wdata = 32'h0; vxsat_set = 1;
    step();
    check_eq("c4_vxsat_clr", {31'b0, vxsat}, 32'd0);

    // vstart priority and read-only vl.
    clear_inputs();
    vstart_wen = 1; vstart_wdata = 7; vec_retire = 1;
    step();
    check_eq("c5_vstart", vstart, 32'd7);
    clear_inputs();
    vec_retire = 1;
    step();
    check_eq("c5_vstart_clr", vstart, 32'd0);
    clear_inputs();
    csr_bus.csr_wen = 1; csr_bus.csr_addr = 12'hC20; csr_bus.csr_wdata = 32'd123;
    step();
    check_eq("c5_vl_ro", vl_arch, 32'd5);

    // Reset right after a mismatching commit cancels the flush.
    clear_inputs();
    vset_commit = 1; avl = 3; vtype_req = mk_vtype(0, 0, 0, 1, 1);
    vl_spec = 9; vtype_spec = mk_vtype(0, 0, 0, 1, 1);
    step();
    check_eq("c6_flush", {31'b0, flush_decode}, 32'd1);
    clear_inputs();
    nRST = 0; vset_commit = 1; avl = 20;
    csr_bus.csr_wen = 1; csr_bus.csr_addr = 12'h00A; csr_bus.csr_wdata = 32'd3;
    step();
    check_eq("c6_flush_rst", {31'b0, flush_decode}, 32'd0);
    check_eq("c6_vl_rst", vl_arch, 32'd0);
    check_eq("c6_vtype_rst", {23'b0, vtype_arch}, 32'd0);
    check_eq("c6_vxrm_rst", {30'b0, vxrm}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      clear_inputs();
      nRST        = ($urandom_range(99, 0) >= 3);
      vset_commit = ($urandom_range(9, 0) < 4);
      vkeepvl     = ($urandom_range(7, 0) == 0);
      case ($urandom_range(3, 0))
        0: avl = $urandom_range(40, 0);
        1: avl = VLMAX;
        2: avl = VLMAX + 1;
        default: avl = $urandom;
      endcase
      vtype_req = mk_vtype($urandom_range(1, 0), $urandom_range(7, 0) == 0,
                           $urandom_range(7, 0) == 0, $urandom_range(3, 0),
                           $urandom_range(7, 0));
      vl_spec    = ($urandom_range(1, 0) == 1) ? 32'(model_new_vl()) : $urandom_range(40, 0);
      vtype_spec = ($urandom_range(1, 0) == 1) ? vtype_req : vtype_t'($urandom_range(511, 0));
      csr_bus.csr_wen   = ($urandom_range(3, 0) == 0);
      csr_bus.csr_addr  = addr_tab[$urandom_range(7, 0)];
      csr_bus.csr_wdata = ($urandom_range(1, 0) == 1) ? $urandom : $urandom_range(7, 0);
      csr_bus.csr_raddr = addr_tab[$urandom_range(7, 0)];
      vxsat_set    = ($urandom_range(4, 0) == 0);
      vstart_wen   = ($urandom_range(7, 0) == 0);
      vstart_wdata = $urandom_range(255, 0);
      vec_retire   = ($urandom_range(3, 0) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
